// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the M-extension multiply/divide unit.
// Optional fast multiplier is selected by MULDIV_FASTMUL_EN (see muldiv_ctrl).
package muldiv_pkg;

  typedef enum logic [2:0] {
    F_MUL    = 3'd0,
    F_MULH   = 3'd1,
    F_MULHSU = 3'd2,
    F_MULHU  = 3'd3,
    F_DIV    = 3'd4,
    F_DIVU   = 3'd5,
    F_REM    = 3'd6,
    F_REMU   = 3'd7
  } func_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int          ITER_COUNT = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  // Magnitude of a 32-bit operand; INT_MIN maps to 2^31 as an unsigned value.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic signed_op);
    return (signed_op && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: 32 shift-add multiply steps or 32 restoring divide steps
// on unsigned magnitudes, one step per enable.
module muldiv_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        is_div,
  input  logic [31:0] a_mag,
  input  logic [31:0] b_mag,
  output logic [63:0] acc_next,
  output logic        last
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic        div_q, div_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] sum, rem_sh, trial;

  // acc holds {partial product hi, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    sum    = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    rem_sh = acc_q[63:31];
    trial  = rem_sh - {1'b0, b_q};
    if (div_q) begin
      acc_next = trial[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                           : {trial[31:0], acc_q[30:0], 1'b1};
    end else begin
      acc_next = {sum, acc_q[31:1]};
    end

    acc_d = acc_q;
    b_d   = b_q;
    div_d = div_q;
    cnt_d = cnt_q;
    if (load) begin
      acc_d = {32'd0, a_mag};
      b_d   = b_mag;
      div_d = is_div;
      cnt_d = '0;
    end else if (step) begin
      acc_d = acc_next;
      cnt_d = cnt_q + 6'd1;
    end
  end

  assign last = (cnt_q == 6'(ITER_COUNT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// M-extension multiply/divide controller: FSM, pipeline stall, special cases.
// Define MULDIV_FASTMUL_EN for a single-cycle combinational multiplier.
module muldiv_ctrl
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        startE,
  input  logic [2:0]  funcE,
  input  logic [31:0] srcAE,
  input  logic [31:0] srcBE,
  input  logic        flushE,
  output logic        stallE,
  output logic        doneE,
  output logic        busyE,
  output logic [31:0] resultE
);

  state_e      state_q, state_d;
  func_e       func_q, func_d, func_in;
  logic [31:0] result_q, result_d;
  logic        neg_q, neg_d, nega_q, nega_d;

  logic        div_op, sign_a, sign_b, a_neg, b_neg;
  logic        accept, div_zero, overflow, fast;
  logic [31:0] a_mag, b_mag, special_res, fast_res, final_res;
  logic [31:0] quot_fix, rem_fix;
  logic [63:0] acc_next, prod_fix;
  logic        last, core_step;

  assign func_in = func_e'(funcE);

  always_comb begin
    div_op   = funcE[2];
    sign_a   = func_in inside {F_MULH, F_MULHSU, F_DIV, F_REM};
    sign_b   = func_in inside {F_MULH, F_DIV, F_REM};
    a_mag    = mag(srcAE, sign_a);
    b_mag    = mag(srcBE, sign_b);
    a_neg    = sign_a & srcAE[31];
    b_neg    = sign_b & srcBE[31];
    accept   = (state_q == S_IDLE) && startE && !flushE;
    div_zero = div_op && (srcBE == 32'd0);
    overflow = (func_in inside {F_DIV, F_REM}) && (srcAE == INT_MIN) && (srcBE == 32'hFFFF_FFFF);
    // funcE[1] separates REM/REMU from DIV/DIVU.
    if (div_zero) special_res = funcE[1] ? srcAE : DIV_ZERO_Q;
    else          special_res = funcE[1] ? 32'd0 : INT_MIN;
  end

`ifdef MULDIV_FASTMUL_EN
  logic signed [65:0] fast_prod;
  always_comb begin
    fast_prod = $signed({a_neg, srcAE}) * $signed({b_neg, srcBE});
    fast      = !div_op;
    fast_res  = (func_in == F_MUL) ? fast_prod[31:0] : fast_prod[63:32];
  end
`else
  assign fast     = 1'b0;
  assign fast_res = 32'd0;
`endif

  // Sign correction is applied to the final core step as it is registered.
  always_comb begin
    prod_fix = neg_q  ? (~acc_next + 64'd1) : acc_next;
    quot_fix = neg_q  ? (~acc_next[31:0] + 32'd1) : acc_next[31:0];
    rem_fix  = nega_q ? (~acc_next[63:32] + 32'd1) : acc_next[63:32];
    case (func_q)
      F_MUL:                      final_res = prod_fix[31:0];
      F_MULH, F_MULHSU, F_MULHU:  final_res = prod_fix[63:32];
      F_DIV, F_DIVU:              final_res = quot_fix;
      default:                    final_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    func_d   = func_q;
    neg_d    = neg_q;
    nega_d   = nega_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          func_d = func_in;
          neg_d  = a_neg ^ b_neg;
          nega_d = a_neg;
          if (div_zero || overflow) begin
            state_d  = S_DONE;
            result_d = special_res;
          end else if (fast) begin
            state_d  = S_DONE;
            result_d = fast_res;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (last) begin
          state_d  = S_DONE;
          result_d = final_res;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flushE) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  assign core_step = (state_q == S_RUN) && !flushE;
  assign stallE    = !flushE && (((state_q == S_IDLE) && startE) || (state_q == S_RUN));
  assign busyE     = (state_q == S_RUN) && !flushE;
  assign doneE     = (state_q == S_DONE) && !flushE;
  assign resultE   = result_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      func_q   <= F_MUL;
      neg_q    <= 1'b0;
      nega_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      func_q   <= func_d;
      neg_q    <= neg_d;
      nega_q   <= nega_d;
    end
  end

  muldiv_core u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .step     (core_step),
    .is_div   (div_op),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .acc_next (acc_next),
    .last     (last)
  );

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: rising-edge clock.
- rst, in, 1: synchronous, active-low reset.
- startE, in, 1: valid M-extension op in execute.
- funcE, in, 3: op code (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
- srcAE, in, 32: forwarded rs1 operand.
- srcBE, in, 32: forwarded rs2 operand.
- flushE, in, 1: kill the execute-stage op.
- stallE, out, 1: hold F/D/E, bubble M.
- doneE, out, 1: result valid this cycle.
- busyE, out, 1: iteration in progress.
- resultE, out, 32: op result.

REQ-002 SHALL have exactly one clock, clk, and one reset, rst, which is synchronous and active-low.

Function
REQ-003 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-004 IDLE, startE=1, flushE=0: SHALL capture srcAE, srcBE and funcE; SHALL assert stallE combinationally in that cycle (cycle 0); SHALL go to RUN, or to DONE for the special cases in REQ-008 and REQ-009.
REQ-005 RUN: SHALL perform exactly 32 iterations, one per cycle (cycles 1..32).
- Multiply: shift-add on 64-bit product magnitudes.
- Divide: restoring, on magnitudes.
- stallE=1 and busyE=1 throughout.
REQ-006 After the 32nd iteration: SHALL enter DONE at cycle 33. DONE SHALL drive doneE=1, stallE=0 and a valid resultE, then go to IDLE unconditionally.
REQ-007 Signed ops SHALL use operand magnitudes, with sign correction applied once before DONE.
- MULH: signed x signed.
- MULHSU: signed x unsigned.
- MUL returns product[31:0]; MULH/MULHSU/MULHU return product[63:32].
- Quotient sign is signA^signB; remainder sign is signA.
REQ-008 Divide by zero (srcBE=0): SHALL skip RUN (IDLE->DONE, doneE at cycle 1).
- Quotient = 0xFFFFFFFF.
- Remainder = dividend.
REQ-009 Signed overflow (DIV/REM, srcAE=0x80000000, srcBE=0xFFFFFFFF): SHALL skip RUN (IDLE->DONE).
- Quotient = 0x80000000.
- Remainder = 0.
REQ-010 flushE=1 in any state: SHALL return to IDLE next cycle.
- doneE and busyE SHALL not assert from the aborted op.
- stallE SHALL be 0 in the flush cycle.
REQ-011 IDLE with startE=0: stallE=0, doneE=0, busyE=0; resultE SHALL hold its last value.
REQ-012 DONE SHALL ignore startE; a new op is accepted only from IDLE, so a still-asserted startE in DONE does not restart.
REQ-013 Operands SHALL be sampled only at IDLE acceptance; later changes on srcAE/srcBE SHALL have no effect.

Reset
REQ-014 rst=0 at a rising clk edge SHALL force the following, including mid-RUN, with no partial result emitted:
- state to IDLE;
- iteration counter to 0;
- stallE, doneE and busyE to 0;
- resultE to 0x00000000.

Configuration
REQ-015 Macro MULDIV_FASTMUL_EN SHALL control the multiply path.
- Defined: MUL/MULH/MULHSU/MULHU SHALL compute in a single-cycle combinational 32x32 multiplier (IDLE->DONE, doneE at cycle 1); divides are unchanged.
- Undefined: all multiplies SHALL use the 32-iteration path (doneE at cycle 33) and no multiplier SHALL be inferred.

Structure
REQ-016 Package muldiv_pkg SHALL hold:
- funcE encodings;
- FSM state encoding;
- ITER_COUNT=32;
- DIV_ZERO_Q=0xFFFFFFFF;
- INT_MIN=0x80000000.
REQ-017 The iterative datapath SHALL be sub-module muldiv_core:
- holds the accumulator, operand and counter registers;
- one step per enable;
- muldiv_ctrl holds the FSM, stall logic and special-case detection.

Verification
REQ-018 MUL 7 x 0xFFFFFFFD (-3) -> stallE high cycles 0..32, doneE at cycle 33, resultE 0xFFFFFFEB.
REQ-019 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> resultE 0xFFFFFFFE (cycle 33; cycle 1 with MULDIV_FASTMUL_EN).
REQ-020 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at cycle 1; REM with the same operands -> 0x00000000.
REQ-021 DIVU 100 / 0 -> 0xFFFFFFFF at cycle 1; REMU 100 / 0 -> 0x00000064.
REQ-022 DIV 20 / 3 with flushE at cycle 10 -> stallE=0 in cycle 10 and no doneE; rerun DIV -20 / 3 -> 0xFFFFFFFA, REM -> 0xFFFFFFFE.
REQ-023 rst=0 at cycle 15 of a DIVU -> all outputs zero next cycle; new DIVU 9 / 2 -> 0x00000004 at cycle 33.
